// File: rtl/uvc_payload_scheduler.sv
// uvc_payload_scheduler
//
// Paces the UVC payload packetizer. Frame ticks come from the USB SOF
// microframe stream (one tick every FRAME_INTERVAL microframes). Each frame
// is split into isochronous payloads, and at most PKTS_PER_UFRAME payloads
// start per microframe. For every payload the block supplies the byte
// count and the header FID/EOF bits.
//
// Ports:
//   CLK_I         in   1  clock
//   RST_I         in   1  asynchronous reset, active high
//   SOF_I         in   1  raw SOF level from the USB core (async to CLK_I)
//   EN_I          in   1  streaming enable, sampled at frame ticks
//   FIFO_EMPTY_I  in   1  endpoint FIFO empty, sampled at frame ticks
//   PKT_DONE_I    in   1  pulse: packetizer finished the current payload
//   PKT_START_O   out  1  pulse: start a payload
//   PKT_LEN_O     out 16  payload bytes including header
//   FID_O         out  1  header frame ID bit
//   EOF_O         out  1  header end-of-frame bit
//   VS_O          out  1  frame in progress
//   OVERRUN_O     out  1  sticky: frame tick seen while a frame was active
//
// state  | meaning
// IDLE   | no frame active, waiting for a frame tick
// ISSUE  | one cycle: PKT_START_O pulses, payload length/EOF already valid
// BUSY   | payload in flight, waiting for PKT_DONE_I
// GAP    | microframe payload budget used up, waiting for the next SOF

module uvc_payload_scheduler #(
    parameter int unsigned FRAME_SIZE      = 614400,
    parameter int unsigned PAYLOAD_SIZE    = 3072,
    parameter int unsigned HDR_LEN         = 12,
    parameter int unsigned FRAME_INTERVAL  = 104,
    parameter int unsigned PKTS_PER_UFRAME = 1
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        SOF_I,
    input  logic        EN_I,
    input  logic        FIFO_EMPTY_I,
    input  logic        PKT_DONE_I,
    output logic        PKT_START_O,
    output logic [15:0] PKT_LEN_O,
    output logic        FID_O,
    output logic        EOF_O,
    output logic        VS_O,
    output logic        OVERRUN_O
);

    localparam int          UCNT_W      = (FRAME_INTERVAL > 1) ? $clog2(FRAME_INTERVAL) : 1;
    localparam logic [31:0] C_FRAME     = 32'(FRAME_SIZE);
    localparam logic [31:0] C_MAX_DATA  = 32'(PAYLOAD_SIZE - HDR_LEN);
    localparam logic [31:0] C_HDR       = 32'(HDR_LEN);
    localparam logic [1:0]  C_PPU       = 2'(PKTS_PER_UFRAME);
    localparam logic [UCNT_W-1:0] C_UCNT_LAST = UCNT_W'(FRAME_INTERVAL - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_sof_meta;
    logic               r_sof_sync;
    logic               r_sof_prev;
    logic [UCNT_W-1:0]  r_ucnt;
    logic [1:0]         r_pcnt;
    logic [31:0]        r_remaining;
    logic [31:0]        r_dlen;
    logic [15:0]        r_pkt_len;
    logic               r_eof;
    logic               r_fid;
    logic               r_vs;
    logic               r_overrun;

    logic               w_sof_rise;
    logic               w_tick;
    logic               w_pkt_start;
    logic [1:0]         w_pcnt_eff;
    logic [31:0]        w_rem_nxt;
    logic [31:0]        w_dlen_nxt;
    logic               w_frame_start;
    logic               w_frame_done;

    // Edge detect on the synchronized level, one flop behind the
    // two-flop synchronizer so the metastable stage is never decoded.
    assign w_sof_rise  = r_sof_sync & ~r_sof_prev;
    assign w_tick      = w_sof_rise & (r_ucnt == '0);
    assign w_pkt_start = (r_state == ST_ISSUE);

    // A SOF arriving in the same cycle as PKT_DONE_I opens a fresh
    // microframe budget, so the decision uses the already-cleared count.
    assign w_pcnt_eff  = w_sof_rise ? 2'd0 : r_pcnt;

    assign w_dlen_nxt  = (w_rem_nxt < C_MAX_DATA) ? w_rem_nxt : C_MAX_DATA;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_rem_nxt     = r_remaining;
        w_frame_start = 1'b0;
        w_frame_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_tick && EN_I && FIFO_EMPTY_I) begin
                    w_rem_nxt     = C_FRAME;
                    w_frame_start = 1'b1;
                    w_state_nxt   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                if (PKT_DONE_I) begin
                    w_rem_nxt = r_remaining - r_dlen;
                    if (w_rem_nxt == '0) begin
                        w_frame_done = 1'b1;
                        w_state_nxt  = ST_IDLE;
                    end else if (w_pcnt_eff < C_PPU) begin
                        w_state_nxt = ST_ISSUE;
                    end else begin
                        w_state_nxt = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (w_sof_rise) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_sof_meta  <= 1'b0;
            r_sof_sync  <= 1'b0;
            r_sof_prev  <= 1'b0;
            r_ucnt      <= '0;
            r_pcnt      <= 2'd0;
            r_remaining <= '0;
            r_dlen      <= '0;
            r_pkt_len   <= '0;
            r_eof       <= 1'b0;
            r_fid       <= 1'b0;
            r_vs        <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_sof_meta  <= SOF_I;
            r_sof_sync  <= r_sof_meta;
            r_sof_prev  <= r_sof_sync;
            r_remaining <= w_rem_nxt;

            if (w_sof_rise) begin
                r_ucnt <= (r_ucnt == C_UCNT_LAST) ? '0 : r_ucnt + 1'b1;
            end

            if (w_sof_rise) begin
                r_pcnt <= w_pkt_start ? 2'd1 : 2'd0;
            end else if (w_pkt_start) begin
                r_pcnt <= r_pcnt + 2'd1;
            end

            // Length and EOF are latched on entry to ISSUE so they are
            // already valid in the PKT_START_O cycle and hold until the next.
            if (w_state_nxt == ST_ISSUE) begin
                r_dlen    <= w_dlen_nxt;
                r_pkt_len <= 16'(w_dlen_nxt + C_HDR);
                r_eof     <= (w_rem_nxt == w_dlen_nxt);
            end

            if (w_frame_start) begin
                r_vs <= 1'b1;
            end else if (w_frame_done) begin
                r_vs <= 1'b0;
            end

            if (w_frame_done) begin
                r_fid <= ~r_fid;
            end

            if (w_tick && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign PKT_START_O = w_pkt_start;
    assign PKT_LEN_O   = r_pkt_len;
    assign FID_O       = r_fid;
    assign EOF_O       = r_eof;
    assign VS_O        = r_vs;
    assign OVERRUN_O   = r_overrun;

endmodule

// File: tb/tb_uvc_payload_scheduler.sv
module tb_uvc_payload_scheduler;

    localparam int EXP_LEN[4] = '{44, 44, 44, 16};
    localparam int EXP_EOF[4] = '{0, 0, 0, 1};
    localparam int EXP_UF_B[4] = '{0, 0, 1, 1};

    logic        CLK_I = 1'b0;
    logic        RST_I = 1'b1;

    // instance A: one payload per microframe, 8 microframes per frame
    logic        sof_a = 1'b0, en_a = 1'b1, fe_a = 1'b1, done_a = 1'b0, mdone_a = 1'b0;
    logic        start_a, fid_a, eof_a, vs_a, ovr_a;
    logic [15:0] len_a;
    // instance B: two payloads per microframe, 2 microframes per frame
    logic        sof_b = 1'b0, en_b = 1'b1, fe_b = 1'b1, done_b = 1'b0, mdone_b = 1'b0;
    logic        start_b, fid_b, eof_b, vs_b, ovr_b;
    logic [15:0] len_b;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int uf_a = 0, cur_uf_a = 0, uf_b = 0, cur_uf_b = 0;
    int dcnt_a = 0, dcnt_b = 0;
    logic auto_a = 1'b1, auto_b = 1'b1;
    logic prev_done_a = 1'b0, prev_done_b = 1'b0;
    logic vs_seen_a = 1'b0;
    logic found;

    int q_len_a[$], q_eof_a[$], q_fid_a[$], q_vs_a[$], q_uf_a[$];
    int q_vsat_a[$], q_vsd_a[$], q_fidd_a[$];
    int q_len_b[$], q_eof_b[$], q_uf_b[$], q_cyc_b[$], q_dcyc_b[$];
    int q_vsd_b[$], q_fidd_b[$];

    uvc_payload_scheduler #(
        .FRAME_SIZE(100), .PAYLOAD_SIZE(44), .HDR_LEN(12),
        .FRAME_INTERVAL(8), .PKTS_PER_UFRAME(1)
    ) u_dut_a (
        .CLK_I(CLK_I), .RST_I(RST_I), .SOF_I(sof_a), .EN_I(en_a),
        .FIFO_EMPTY_I(fe_a), .PKT_DONE_I(done_a | mdone_a),
        .PKT_START_O(start_a), .PKT_LEN_O(len_a), .FID_O(fid_a),
        .EOF_O(eof_a), .VS_O(vs_a), .OVERRUN_O(ovr_a)
    );

    uvc_payload_scheduler #(
        .FRAME_SIZE(100), .PAYLOAD_SIZE(44), .HDR_LEN(12),
        .FRAME_INTERVAL(2), .PKTS_PER_UFRAME(2)
    ) u_dut_b (
        .CLK_I(CLK_I), .RST_I(RST_I), .SOF_I(sof_b), .EN_I(en_b),
        .FIFO_EMPTY_I(fe_b), .PKT_DONE_I(done_b | mdone_b),
        .PKT_START_O(start_b), .PKT_LEN_O(len_b), .FID_O(fid_b),
        .EOF_O(eof_b), .VS_O(vs_b), .OVERRUN_O(ovr_b)
    );

    always #5 CLK_I = ~CLK_I;

    always @(posedge CLK_I) cyc = cyc + 1;

    // Packetizer model: answers each start with a done pulse 5 cycles later.
    always @(negedge CLK_I) begin
        done_a = 1'b0;
        if (dcnt_a != 0) begin
            dcnt_a = dcnt_a - 1;
            if (dcnt_a == 0) done_a = 1'b1;
        end
        if (start_a && auto_a) dcnt_a = 5;
        done_b = 1'b0;
        if (dcnt_b != 0) begin
            dcnt_b = dcnt_b - 1;
            if (dcnt_b == 0) done_b = 1'b1;
        end
        if (start_b && auto_b) dcnt_b = 5;
    end

    // Recorder: sampled just after the falling edge, mid-cycle.
    always @(negedge CLK_I) begin
        #1;
        if (vs_a) vs_seen_a = 1'b1;
        if (prev_done_a) begin
            q_vsd_a.push_back(int'(vs_a));
            q_fidd_a.push_back(int'(fid_a));
        end
        prev_done_a = done_a | mdone_a;
        if (prev_done_a) q_vsat_a.push_back(int'(vs_a));
        if (start_a) begin
            q_len_a.push_back(int'(len_a));
            q_eof_a.push_back(int'(eof_a));
            q_fid_a.push_back(int'(fid_a));
            q_vs_a.push_back(int'(vs_a));
            q_uf_a.push_back(cur_uf_a);
        end
        if (prev_done_b) begin
            q_vsd_b.push_back(int'(vs_b));
            q_fidd_b.push_back(int'(fid_b));
        end
        prev_done_b = done_b | mdone_b;
        if (prev_done_b) q_dcyc_b.push_back(cyc);
        if (start_b) begin
            q_len_b.push_back(int'(len_b));
            q_eof_b.push_back(int'(eof_b));
            q_uf_b.push_back(cur_uf_b);
            q_cyc_b.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic ufr_a();
        @(negedge CLK_I);
        cur_uf_a = uf_a;
        sof_a = 1'b1;
        repeat (15) @(negedge CLK_I);
        sof_a = 1'b0;
        repeat (15) @(negedge CLK_I);
        uf_a++;
    endtask

    task automatic ufr_b();
        @(negedge CLK_I);
        cur_uf_b = uf_b;
        sof_b = 1'b1;
        repeat (15) @(negedge CLK_I);
        sof_b = 1'b0;
        repeat (15) @(negedge CLK_I);
        uf_b++;
    endtask

    task automatic clear_a();
        q_len_a.delete(); q_eof_a.delete(); q_fid_a.delete(); q_vs_a.delete();
        q_uf_a.delete(); q_vsat_a.delete(); q_vsd_a.delete(); q_fidd_a.delete();
        vs_seen_a = 1'b0;
    endtask

    task automatic clear_b();
        q_len_b.delete(); q_eof_b.delete(); q_uf_b.delete(); q_cyc_b.delete();
        q_dcyc_b.delete(); q_vsd_b.delete(); q_fidd_b.delete();
    endtask

    task automatic check_frame_a(input string tag);
        check({tag, "_starts"}, q_len_a.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < q_len_a.size()) begin
                check($sformatf("%s_len%0d", tag, i), q_len_a[i], EXP_LEN[i]);
                check($sformatf("%s_eof%0d", tag, i), q_eof_a[i], EXP_EOF[i]);
            end
        end
    endtask

    initial begin
        repeat (5) @(negedge CLK_I);
        #1;
        check("rst_start", start_a, 0);
        check("rst_len", len_a, 0);
        check("rst_fid", fid_a, 0);
        check("rst_eof", eof_a, 0);
        check("rst_vs", vs_a, 0);
        check("rst_ovr", ovr_a, 0);
        @(negedge CLK_I);
        RST_I = 1'b0;
        repeat (3) @(negedge CLK_I);

        // basic frame: 44,44,44,16 across microframes 0..3
        clear_a();
        repeat (8) ufr_a();
        check_frame_a("basic");
        for (int i = 0; i < 4; i++) begin
            if (i < q_uf_a.size()) begin
                check($sformatf("basic_uf%0d", i), q_uf_a[i], i);
                check($sformatf("basic_fid%0d", i), q_fid_a[i], 0);
                check($sformatf("basic_vs%0d", i), q_vs_a[i], 1);
            end
        end
        check("basic_dones", q_vsd_a.size(), 4);
        if (q_vsd_a.size() == 4) begin
            check("basic_vs_at_last_done", q_vsat_a[3], 1);
            check("basic_vs_after_last_done", q_vsd_a[3], 0);
            check("basic_fid_after_last_done", q_fidd_a[3], 1);
        end
        check("basic_ovr", ovr_a, 0);

        // FIFO not empty at the tick: frame skipped
        clear_a();
        fe_a = 1'b0;
        ufr_a();
        fe_a = 1'b1;
        repeat (7) ufr_a();
        check("skip_starts", q_len_a.size(), 0);
        check("skip_vs", vs_seen_a, 0);
        clear_a();
        repeat (8) ufr_a();
        check_frame_a("after_skip");
        if (q_fid_a.size() > 0) check("after_skip_fid", q_fid_a[0], 1);
        if (q_fidd_a.size() == 4) check("after_skip_fid_end", q_fidd_a[3], 0);

        // stray done in IDLE
        clear_a();
        @(negedge CLK_I); mdone_a = 1'b1;
        @(negedge CLK_I); mdone_a = 1'b0;
        repeat (5) @(negedge CLK_I);
        check("stray_starts", q_len_a.size(), 0);
        check("stray_vs", vs_seen_a, 0);

        // EN_I dropped after the second payload
        clear_a();
        repeat (2) ufr_a();
        check("endrop_two_started", q_len_a.size(), 2);
        en_a = 1'b0;
        repeat (6) ufr_a();
        check_frame_a("endrop");
        if (q_uf_a.size() > 0) check("endrop_first_uf", q_uf_a[0], 24);
        if (q_fidd_a.size() == 4) check("endrop_fid_end", q_fidd_a[3], 1);
        vs_seen_a = 1'b0;
        repeat (8) ufr_a();
        check("endrop_no_new_frame", q_len_a.size(), 4);
        check("endrop_no_vs", vs_seen_a, 0);

        // reset while BUSY
        en_a = 1'b1;
        clear_a();
        @(negedge CLK_I);
        cur_uf_a = uf_a;
        sof_a = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK_I);
            #1;
            if (start_a) begin
                found = 1'b1;
                break;
            end
        end
        check("rstbusy_started", found, 1);
        repeat (2) @(negedge CLK_I);
        #1;
        check("rstbusy_pre_vs", vs_a, 1);
        check("rstbusy_pre_fid", fid_a, 1);
        RST_I = 1'b1;
        #1;
        check("rstbusy_start", start_a, 0);
        check("rstbusy_len", len_a, 0);
        check("rstbusy_fid", fid_a, 0);
        check("rstbusy_eof", eof_a, 0);
        check("rstbusy_vs", vs_a, 0);
        check("rstbusy_ovr", ovr_a, 0);
        sof_a = 1'b0;
        repeat (4) @(negedge CLK_I);
        RST_I = 1'b0;
        uf_a = 0;
        repeat (10) @(negedge CLK_I);
        clear_a();
        ufr_a();
        check("rstbusy_restart", q_len_a.size(), 1);
        if (q_len_a.size() > 0) begin
            check("rstbusy_restart_len", q_len_a[0], 44);
            check("rstbusy_restart_fid", q_fid_a[0], 0);
        end

        // two payloads per microframe
        clear_b();
        repeat (2) ufr_b();
        check("two_starts", q_len_b.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < q_len_b.size()) begin
                check($sformatf("two_len%0d", i), q_len_b[i], EXP_LEN[i]);
                check($sformatf("two_eof%0d", i), q_eof_b[i], EXP_EOF[i]);
                check($sformatf("two_uf%0d", i), q_uf_b[i], EXP_UF_B[i]);
            end
        end
        if (q_cyc_b.size() == 4 && q_dcyc_b.size() >= 3) begin
            check("two_b2b_first", q_cyc_b[1], q_dcyc_b[0] + 1);
            check("two_b2b_second", q_cyc_b[3], q_dcyc_b[2] + 1);
        end
        if (q_vsd_b.size() == 4) begin
            check("two_vs_end", q_vsd_b[3], 0);
            check("two_fid_end", q_fidd_b[3], 1);
        end
        check("two_ovr", ovr_b, 0);

        // overrun: done withheld past the next tick
        clear_b();
        auto_b = 1'b0;
        ufr_b();
        ufr_b();
        check("ovr_not_yet", ovr_b, 0);
        ufr_b();
        check("ovr_set", ovr_b, 1);
        ufr_b();
        check("ovr_sticky", ovr_b, 1);
        auto_b = 1'b1;
        @(negedge CLK_I); mdone_b = 1'b1;
        @(negedge CLK_I); mdone_b = 1'b0;
        repeat (20) @(negedge CLK_I);
        ufr_b();
        ufr_b();
        check("ovr_frame_starts", q_len_b.size(), 4);
        if (q_len_b.size() == 4) begin
            check("ovr_last_len", q_len_b[3], 16);
            check("ovr_last_eof", q_eof_b[3], 1);
        end
        check("ovr_vs_end", vs_b, 0);
        check("ovr_fid_end", fid_b, 0);
        check("ovr_still_set", ovr_b, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uvc_payload_scheduler.md
# uvc_payload_scheduler

Sequences the UVC payload packetizer: derives frame start ticks from USB SOF microframes, splits each video frame into isochronous payloads and paces them per microframe. It tells the packetizer when to start each payload, how many bytes it carries, and what header FID/EOF bits to use. It sits between the USB SOF source and the payload/header generator that feeds the endpoint FIFO.

## Interface
- FRAME_SIZE, 614400: image bytes per frame (WIDTH*HEIGHT*2).
- PAYLOAD_SIZE, 3072: maximum payload bytes, header included.
- HDR_LEN, 12: header bytes per payload.
- FRAME_INTERVAL, 104: microframes per frame period.
- PKTS_PER_UFRAME, 1: maximum payloads started per microframe (1..3).

Ports:
- CLK_I  in  1  clock.
- RST_I  in  1  reset, asynchronous, active-high.
- SOF_I  in  1  raw SOF level from the USB core; asynchronous to CLK_I.
- EN_I  in  1  streaming enable.
- FIFO_EMPTY_I  in  1  endpoint FIFO empty.
- PKT_DONE_I  in  1  one-cycle pulse: the packetizer finished the current payload.
- PKT_START_O  out  1  one-cycle pulse: start a payload.
- PKT_LEN_O  out  16  bytes in this payload, header included.
- FID_O  out  1  frame ID bit for the header.
- EOF_O  out  1  end-of-frame bit for the header.
- VS_O  out  1  high while a frame is in progress.
- OVERRUN_O  out  1  sticky: a frame tick arrived while a frame was still active.

## Operation
- **SOF detection:** SOF_I passes through a 2-flop synchronizer. sof_rise = d0 & ~d1.
- **Interval counter:** ucnt counts 0..FRAME_INTERVAL-1. It advances on each sof_rise and wraps to 0. A frame tick is sof_rise while ucnt==0.
- **Microframe packet counter:** pcnt increments on every payload start. sof_rise clears it. If a clear and a start happen in the same cycle, pcnt becomes 1.
- **State IDLE:**
  - A tick with EN_I=1 and FIFO_EMPTY_I=1 loads remaining=FRAME_SIZE (32-bit), sets VS_O and goes to ISSUE.
  - A tick with the FIFO not empty, or with EN_I=0, skips that frame and stays in IDLE.
- **State ISSUE:**
  - dlen = min(remaining, PAYLOAD_SIZE-HDR_LEN).
  - PKT_LEN_O = dlen+HDR_LEN.
  - EOF_O = (remaining == dlen).
  - Pulse PKT_START_O, increment pcnt, go to BUSY.
- **State BUSY:** wait for PKT_DONE_I, then remaining -= dlen.
  - remaining now 0: toggle FID_O, clear VS_O, go to IDLE.
  - Otherwise, pcnt < PKTS_PER_UFRAME: go to ISSUE.
  - Otherwise: go to GAP.
- **State GAP:** wait for sof_rise, then go to ISSUE.
- **PKT_DONE_I** outside BUSY is ignored.
- **EN_I deassertion** mid-frame does not abort; the current frame completes.
- **Overrun:** a tick in any state other than IDLE sets OVERRUN_O, which holds until reset. The active frame continues and the tick is not queued.

## Timing
- **Reset values:** PKT_START_O=0, PKT_LEN_O=0, FID_O=0, EOF_O=0, VS_O=0, OVERRUN_O=0, state IDLE, ucnt=0, pcnt=0.
- **Reset mid-frame:** everything returns immediately to the reset values; no payload completion is expected afterwards.
- **SOF latency:** SOF_I rising edge sampled at cycle s gives sof_rise at cycle s+2.
- **Tick to first payload:** tick in cycle t gives PKT_START_O and VS_O high in cycle t+1.
- **Back-to-back payloads:** PKT_DONE_I in cycle d (more payloads allowed in this microframe) gives the next PKT_START_O in cycle d+1.
- **After GAP:** sof_rise in cycle g gives PKT_START_O in cycle g+1.
- **Frame end:** the last PKT_DONE_I in cycle d gives VS_O=0 and toggled FID_O in cycle d+1.
- **Output hold:** PKT_LEN_O and EOF_O are registered, valid from the PKT_START_O cycle and held until the next PKT_START_O. FID_O stays constant for the whole frame.

## Test plan
- **Basic frame:** FRAME_SIZE=100, PAYLOAD_SIZE=44, PKTS_PER_UFRAME=1, FRAME_INTERVAL=8, FIFO empty, EN=1. Each PKT_START_O answered with PKT_DONE_I 5 cycles later. Required:
  - PKT_LEN_O = 44, 44, 44, 16 in four consecutive microframes.
  - EOF_O=1 only on the 16-byte payload.
  - FID_O toggles 0→1 after it; VS_O falls the cycle after the last PKT_DONE_I.
- **Two per microframe:** same as above with PKTS_PER_UFRAME=2. Required:
  - Payloads 1–2 in microframe 0, payloads 3–4 in microframe 1.
  - Second start exactly 1 cycle after the first PKT_DONE_I.
- **FIFO not empty at tick:** FIFO_EMPTY_I=0 at the tick. Required: no PKT_START_O and VS_O=0 for that frame period. The next tick with the FIFO empty starts a frame with FID_O unchanged.
- **Overrun:** FRAME_INTERVAL=2 with PKT_DONE_I withheld past the next tick. Required: OVERRUN_O=1 and stays high; the frame completes normally when done pulses resume.
- **Stray done and EN_I drop:**
  - PKT_DONE_I in IDLE: no state change.
  - EN_I dropped after the second payload: frame still finishes with 4 payloads; no new frame starts.
- **Reset mid-BUSY:** assert RST_I while in BUSY. Required: all outputs at reset values in the same cycle; after release, the first tick restarts with FID_O=0 and PKT_LEN_O=44.
